// File: rtl/fetch_if.sv
// fetch_if: PC-sequencing and instruction-fetch handshake signals between pipeline, IMEM and fetch_seq.
interface fetch_if;
  logic [31:0] pc;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        exc;
  logic        imem_ack;
  logic [31:0] pc_new;
  logic        pc_en;
  logic        imem_req;
  logic        if_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        fetch_err;
  modport master (
    input  pc, stall, br_taken, br_target, jmp, jmp_target, exc, imem_ack,
    output pc_new, pc_en, imem_req, if_valid, flush_if_id, flush_id_ex, fetch_err
  );
  modport slave (
    output pc, stall, br_taken, br_target, jmp, jmp_target, exc, imem_ack,
    input  pc_new, pc_en, imem_req, if_valid, flush_if_id, flush_id_ex, fetch_err
  );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: next-PC arbitration and IMEM fetch sequencing, draining stale fetches after redirects.
module fetch_seq #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0100,
  parameter int          MAX_WAIT   = 8,
  parameter int          CNT_W      = 4
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout, to_exc, redir, take;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    timeout          = state_q == FETCH && !bus.imem_ack && cnt_q == CNT_W'(MAX_WAIT - 1);
    to_exc           = bus.exc || timeout;
    redir            = state_q != IDLE && (to_exc || bus.br_taken || bus.jmp);
    take             = !redir && state_q == FETCH && bus.imem_ack && !bus.stall;
    bus.imem_req     = state_q == FETCH;
    bus.fetch_err    = timeout;
    bus.flush_if_id  = redir;
    bus.flush_id_ex  = redir && (to_exc || bus.br_taken);
    bus.if_valid     = take;
    bus.pc_en        = redir || take;
    bus.pc_new       = state_q == IDLE ? 32'd0 :
                       to_exc          ? EXC_VECTOR :
                       bus.br_taken    ? bus.br_target :
                       bus.jmp         ? bus.jmp_target : bus.pc + 32'd4;
    // any ack ends the outstanding request; a redirect without one leaves a stale ack to drain
    state_d          = state_q == IDLE ? FETCH :
                       bus.imem_ack    ? FETCH :
                       redir           ? DRAIN : state_q;
    cnt_d            = (state_q == FETCH && state_d == FETCH && !bus.imem_ack) ? cnt_q + 1'b1 : '0;
  end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: scoreboard bench for fetch_seq with directed spec scenarios and randomized traffic.
module tb_fetch_seq;
  localparam logic [31:0] VEC      = 32'h0000_0100;
  localparam int          MAX_WAIT = 8;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_new;
    logic        pc_en;
    logic        req;
    logic        valid;
    logic        fif;
    logic        fie;
    logic        err;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_q;
  fetch_if bus ();
  fetch_seq #(.EXC_VECTOR(VEC), .MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk or posedge rst)
    if (rst) pc_q <= '0;
    else if (bus.pc_en) pc_q <= bus.pc_new;
  assign bus.pc = pc_q;
  exp_t        exp_q[$];
  logic [31:0] fetch_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  bit          m_boot, m_stale;
  int          m_wait;
  logic [31:0] m_pc;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pc", bus.pc, mon_e.pc);
      chk("pc_new", bus.pc_new, mon_e.pc_new);
      chk("pc_en", 32'(bus.pc_en), 32'(mon_e.pc_en));
      chk("imem_req", 32'(bus.imem_req), 32'(mon_e.req));
      chk("if_valid", 32'(bus.if_valid), 32'(mon_e.valid));
      chk("flush_if_id", 32'(bus.flush_if_id), 32'(mon_e.fif));
      chk("flush_id_ex", 32'(bus.flush_id_ex), 32'(mon_e.fie));
      chk("fetch_err", 32'(bus.fetch_err), 32'(mon_e.err));
      if (bus.if_valid) begin
        if (fetch_q.size() == 0) chk("fetch_q_nonempty", 32'(fetch_q.size()), 32'd1);
        else chk("fetch_addr", bus.pc, fetch_q.pop_front());
      end
    end
  end
  task automatic drive(input bit st, br, input logic [31:0] bt, input bit j, input logic [31:0] jt, input bit ex, ack);
    bus.stall = st; bus.br_taken = br; bus.br_target = bt;
    bus.jmp = j; bus.jmp_target = jt; bus.exc = ex; bus.imem_ack = ack;
  endtask
  // Reference: after reset one dead cycle, then a request is outstanding unless a redirect left a stale one.
  task automatic step(input bit st, br, input logic [31:0] bt, input bit j, input logic [31:0] jt, input bit ex, ack);
    exp_t e;
    bit   to, rd;
    drive(st, br, bt, j, jt, ex, ack);
    e = '{default: '0};
    e.pc = m_pc;
    if (m_boot) begin
      m_boot = 0; m_stale = 0; m_wait = 0;
    end else begin
      to = !m_stale && !ack && m_wait == MAX_WAIT - 1;
      rd = ex || to || br || j;
      e.req = !m_stale; e.err = to; e.fif = rd; e.fie = ex || to || br;
      if (rd) begin
        e.pc_en = 1; e.pc_new = (ex || to) ? VEC : br ? bt : jt;
        m_stale = !ack; m_wait = 0;
      end else begin
        e.pc_new = m_pc + 32'd4;
        e.valid = !m_stale && ack && !st;
        e.pc_en = e.valid;
        m_wait = (m_stale || ack) ? 0 : m_wait + 1;
        m_stale = m_stale && !ack;
      end
    end
    if (e.valid) fetch_q.push_back(m_pc);
    exp_q.push_back(e);
    if (e.pc_en) m_pc = e.pc_new;
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_pc_new"}, bus.pc_new, 32'd0);
    chk({tag, "_outs"}, {25'd0, bus.pc_en, bus.imem_req, bus.if_valid, bus.flush_if_id, bus.flush_id_ex, bus.fetch_err, 1'b0}, 32'd0);
    chk({tag, "_pc"}, bus.pc, 32'd0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_zero("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete(); fetch_q.delete();
    m_boot = 1; m_stale = 0; m_wait = 0; m_pc = '0;
  endtask
  initial begin
    int p;
    drive(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (4) step(0, 0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h40, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h80, 1, 32'h90, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 32'h200, 0, 1);
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (MAX_WAIT) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h60, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    do_reset();
    for (int b = 0; b < 8; b++) begin
      p = (b % 4 == 3) ? 10 : 40 + 15 * (b % 4);
      for (int i = 0; i < 60; i++)
        step($urandom_range(99) < 20, $urandom_range(99) < 7, $urandom & 32'hFFFF_FFFC,
             $urandom_range(99) < 7, $urandom & 32'hFFFF_FFFC, $urandom_range(99) < 3,
             $urandom_range(99) < p);
      if (b == 4) begin
        do_reset();
      end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    chk("fetch_drained", 32'(fetch_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
